// File: rtl/text_overlay_pkg.sv
// Shared types for the text overlay: cell layout, blank character and controller states.
package text_overlay_pkg;

   typedef struct packed {
      logic [3:0] attr;   // bit3 blink, bits2:0 colour
      logic [6:0] ch;
   } cell_t;

   localparam int         CELL_W     = 11;
   localparam logic [6:0] SPACE_CODE = 7'h20;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

endpackage

// File: rtl/font_rom.sv
// 8x16 glyph ROM addressed by {char, glyph_row}; one-cycle registered read, bit 7 is leftmost.
module font_rom (
   input  logic        clk,
   input  logic [10:0] addr,
   output logic [7:0]  data
);

   logic [7:0] rom_word;

   always_comb begin
      rom_word = 8'h00;
      case (addr)
         11'h412: rom_word = 8'h10;
         11'h413: rom_word = 8'h38;
         11'h414: rom_word = 8'h6C;
         11'h415: rom_word = 8'hC6;
         11'h416: rom_word = 8'hC6;
         11'h417: rom_word = 8'hFE;
         11'h418: rom_word = 8'hC6;
         11'h419: rom_word = 8'hC6;
         11'h41A: rom_word = 8'hC6;
         11'h41B: rom_word = 8'hC6;
         default: rom_word = (addr[10:4] == 7'h7F) ? 8'hFF : 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      data <= rom_word;
   end

endmodule

// File: rtl/text_char_ram.sv
// Character cell store: one write port, one read port, read-first on address collision.
module text_char_ram #(
   parameter int DEPTH = 64,
   parameter int AW    = 6,
   parameter int DW    = 11
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   // NOTE: the array has no reset; contents are defined by the clear sweep that follows reset.
   logic [DW-1:0] mem [DEPTH];

   // NOTE: non-blocking updates make a same-cycle read see the old word (read-first).
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/text_overlay.sv
// Character-cell text overlay: write/clear controller, blink timer and 3-stage pixel pipeline.
module text_overlay
   import text_overlay_pkg::*;
#(
   parameter int COLS         = 16,
   parameter int ROWS         = 4,
   parameter int SCALE_LOG2   = 1,
   parameter int X0           = 64,
   parameter int Y0           = 64,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [10:0]             pix_x,
   input  logic [10:0]             pix_y,
   input  logic                    frame_tick,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [$clog2(COLS)-1:0] wr_col,
   input  logic [$clog2(ROWS)-1:0] wr_row,
   input  logic [6:0]              wr_char,
   input  logic [3:0]              wr_attr,
   input  logic                    clear_req,
   output logic                    text_on,
   output logic [2:0]              text_rgb
);

   localparam int CELLS = COLS * ROWS;
   localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
   localparam int CW    = $clog2(COLS);
   localparam int RW    = $clog2(ROWS);
   localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [11:0]   X_LO     = 12'(X0);
   localparam logic [11:0]   X_HI     = 12'(X0 + ((COLS * 8) << SCALE_LOG2));
   localparam logic [11:0]   Y_LO     = 12'(Y0);
   localparam logic [11:0]   Y_HI     = 12'(Y0 + ((ROWS * 16) << SCALE_LOG2));
   localparam logic [AW-1:0] LAST     = AW'(CELLS - 1);
   localparam logic [FC_W-1:0] FC_END = FC_W'(BLINK_FRAMES - 1);

   // ---------------- write / clear controller ----------------
   state_t        state, state_nx;
   logic [AW-1:0] clr_idx, clr_idx_nx;
   logic          ram_we;
   logic [AW-1:0] ram_waddr, ram_raddr;
   cell_t         ram_wdata;
   logic          wr_in_range;
   logic [AW-1:0] wr_addr;

   assign wr_in_range = ({1'b0, wr_col} < (CW+1)'(COLS)) && ({1'b0, wr_row} < (RW+1)'(ROWS));
   assign wr_addr     = AW'(16'(wr_row) * 16'(COLS) + 16'(wr_col));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= ST_CLEAR;
         clr_idx <= '0;
      end else begin
         state   <= state_nx;
         clr_idx <= clr_idx_nx;
      end
   end

   // NOTE: every output of this block gets a default first so no path infers a latch.
   always_comb begin
      state_nx   = state;
      clr_idx_nx = clr_idx;
      wr_ready   = 1'b0;
      ram_we     = 1'b0;
      ram_waddr  = clr_idx;
      ram_wdata  = '{attr: 4'h0, ch: SPACE_CODE};
      case (state)
         ST_CLEAR: begin
            ram_we = 1'b1;
            if (clear_req) begin
               clr_idx_nx = '0;
            end else if (clr_idx == LAST) begin
               clr_idx_nx = '0;
               state_nx   = ST_IDLE;
            end else begin
               clr_idx_nx = clr_idx + AW'(1);
            end
         end
         ST_IDLE: begin
            wr_ready = 1'b1;
            if (wr_valid && wr_in_range) begin
               ram_we    = 1'b1;
               ram_waddr = wr_addr;
               ram_wdata = '{attr: wr_attr, ch: wr_char};
            end
            if (clear_req) begin
               state_nx   = ST_CLEAR;
               clr_idx_nx = '0;
            end
         end
         default: state_nx = ST_CLEAR;
      endcase
   end

   // ---------------- blink timer ----------------
   logic [FC_W-1:0] frame_cnt;
   logic            blink_phase;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_tick) begin
         if (frame_cnt == FC_END) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt <= frame_cnt + FC_W'(1);
         end
      end
   end

   // ---------------- pixel pipeline ----------------
   logic [11:0] px, py, dx, dy, sx, sy;
   logic        in_win;

   assign px        = {1'b0, pix_x};
   assign py        = {1'b0, pix_y};
   assign in_win    = (px >= X_LO) && (px < X_HI) && (py >= Y_LO) && (py < Y_HI);
   assign dx        = px - X_LO;
   assign dy        = py - Y_LO;
   assign sx        = dx >> SCALE_LOG2;
   assign sy        = dy >> SCALE_LOG2;
   assign ram_raddr = AW'(16'(sy[11:4]) * 16'(COLS) + 16'(sx[11:3]));

   logic [CELL_W-1:0] ram_rdata;
   cell_t             s1_cell;
   logic              s1_valid, s1_in_win, s2_valid, s2_in_win;
   logic [3:0]        s1_row, s2_attr;
   logic [2:0]        s1_bit, s2_bit;
   logic [7:0]        font_word;
   logic              lit;

   text_char_ram #(.DEPTH(CELLS), .AW(AW), .DW(CELL_W)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   assign s1_cell = cell_t'(ram_rdata);

   font_rom u_font (
      .clk  (clk),
      .addr ({s1_cell.ch, s1_row}),
      .data (font_word)
   );

   // Offsets and window flag travel with the RAM and ROM latencies.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_valid  <= 1'b0;
         s1_in_win <= 1'b0;
         s1_row    <= '0;
         s1_bit    <= '0;
         s2_valid  <= 1'b0;
         s2_in_win <= 1'b0;
         s2_bit    <= '0;
         s2_attr   <= '0;
      end else begin
         s1_valid  <= 1'b1;
         s1_in_win <= in_win;
         s1_row    <= sy[3:0];
         s1_bit    <= sx[2:0];
         s2_valid  <= s1_valid;
         s2_in_win <= s1_in_win;
         s2_bit    <= s1_bit;
         s2_attr   <= s1_cell.attr;
      end
   end

   assign lit = s2_valid && s2_in_win && font_word[~s2_bit] && !(s2_attr[3] && blink_phase);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         text_on  <= 1'b0;
         text_rgb <= 3'b000;
      end else begin
         text_on  <= lit;
         text_rgb <= lit ? s2_attr[2:0] : 3'b000;
      end
   end

endmodule

// File: tb/tb_text_overlay.sv
// Scoreboard bench for text_overlay: expected pixels are queued at drive time and compared 3 cycles later.
module tb_text_overlay;

   localparam int COLS  = 12;
   localparam int ROWS  = 3;
   localparam int CELLS = COLS * ROWS;
   localparam int BLINK = 30;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [10:0] pix_x, pix_y;
   logic        frame_tick, wr_valid, wr_ready, clear_req, text_on;
   logic [3:0]  wr_col;
   logic [1:0]  wr_row;
   logic [6:0]  wr_char;
   logic [3:0]  wr_attr;
   logic [2:0]  text_rgb;

   always #5 clk = ~clk;

   text_overlay #(.COLS(COLS), .ROWS(ROWS), .SCALE_LOG2(1), .X0(64), .Y0(64), .BLINK_FRAMES(BLINK)) dut (
      .clk(clk), .reset_n(reset_n), .pix_x(pix_x), .pix_y(pix_y), .frame_tick(frame_tick),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_col(wr_col), .wr_row(wr_row),
      .wr_char(wr_char), .wr_attr(wr_attr), .clear_req(clear_req),
      .text_on(text_on), .text_rgb(text_rgb)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference data: glyph for 'A', cell contents and blink phase.
   logic [7:0]  glyph_a [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                                8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};
   logic [10:0] model [CELLS];
   logic        phase = 1'b0;
   int          ticks_total = 0;

   typedef struct {
      int unsigned due;
      int          x;
      int          y;
      logic        on;
      logic [2:0]  rgb;
   } exp_t;
   exp_t sb[$];

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [3:0] expect_px(input int x, input int y);
      int sx, sy, idx;
      logic [10:0] c;
      logic [7:0]  w;
      logic        on;
      if (x < 64 || x >= 64 + COLS * 16 || y < 64 || y >= 64 + ROWS * 32) return 4'b0;
      sx  = (x - 64) / 2;
      sy  = (y - 64) / 2;
      idx = (sy / 16) * COLS + sx / 8;
      c   = model[idx];
      w   = (c[6:0] == 7'h41) ? glyph_a[sy % 16] : 8'h00;
      on  = w[7 - sx % 8] && !(c[10] && phase);
      return on ? {1'b1, c[9:7]} : 4'b0;
   endfunction

   task automatic pix(input int x, input int y, input bit push);
      exp_t e;
      logic [3:0] ex;
      @(negedge clk);
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         check($sformatf("on(%0d,%0d)", e.x, e.y), text_on, e.on);
         check($sformatf("rgb(%0d,%0d)", e.x, e.y), text_rgb, e.rgb);
      end
      pix_x = 11'(x);
      pix_y = 11'(y);
      if (push) begin
         ex = expect_px(x, y);
         sb.push_back('{cyc + 3, x, y, ex[3], ex[2:0]});
      end
   endtask

   task automatic scan(input int x0, input int x1, input int y0, input int y1, input int ystep);
      for (int y = y0; y <= y1; y += ystep)
         for (int x = x0; x <= x1; x++) pix(x, y, 1'b1);
      repeat (3) pix(0, 0, 1'b0);
   endtask

   task automatic wr(input int col, input int row, input logic [6:0] ch, input logic [3:0] attr, input string tag);
      int n = 0;
      @(negedge clk);
      wr_valid = 1'b1; wr_col = 4'(col); wr_row = 2'(row); wr_char = ch; wr_attr = attr;
      while (!wr_ready && n < 200) begin @(negedge clk); n++; end
      check({tag, "_ready"}, wr_ready, 1);
      @(negedge clk);
      wr_valid = 1'b0;
      if (col < COLS && row < ROWS) model[row * COLS + col] = {attr, ch};
   endtask

   task automatic count_low(output int cnt);
      cnt = 0;
      while (!wr_ready && cnt < 1000) begin cnt++; @(negedge clk); end
   endtask

   task automatic model_clear();
      for (int i = 0; i < CELLS; i++) model[i] = {4'h0, 7'h20};
   endtask

   task automatic mem_check(input string tag);
      for (int i = 0; i < CELLS; i++) check($sformatf("%s[%0d]", tag, i), dut.u_ram.mem[i], model[i]);
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         @(negedge clk); frame_tick = 1'b1;
         @(negedge clk); frame_tick = 1'b0;
         ticks_total++;
         if (ticks_total % BLINK == 0) phase = ~phase;
      end
   endtask

   int cnt;

   initial begin
      reset_n = 1'b0; pix_x = '0; pix_y = '0; frame_tick = 1'b0; wr_valid = 1'b0;
      wr_col = '0; wr_row = '0; wr_char = '0; wr_attr = '0; clear_req = 1'b0;
      repeat (2) @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
      check("rst_text_on", text_on, 0);
      check("rst_text_rgb", text_rgb, 0);
      check("rst_wr_ready", wr_ready, 0);
      check("rst_frame_cnt", dut.frame_cnt, 0);
      check("rst_blink", dut.blink_phase, 0);

      // Automatic clear after reset release
      reset_n = 1'b1;
      count_low(cnt);
      check("init_clear_len", cnt, CELLS);
      model_clear();
      mem_check("init_mem");

      // Glyph rendering and pipeline latency
      wr(0, 0, 7'h41, 4'b0010, "wr_a");
      scan(60, 84, 62, 98, 2);

      // Out-of-range writes complete but change nothing
      wr(COLS, 0, 7'h41, 4'b0111, "wr_badcol");
      wr(0, ROWS, 7'h41, 4'b0111, "wr_badrow");
      mem_check("bad_wr_mem");

      // Blink suppression over two half-periods
      wr(1, 0, 7'h41, 4'b1101, "wr_blink");
      scan(64, 100, 78, 78, 1);
      ticks(BLINK);
      check("blink_phase_30", dut.blink_phase, phase);
      scan(64, 100, 78, 78, 1);
      ticks(BLINK);
      scan(64, 100, 78, 78, 1);

      // Write and clear in the same cycle, then restart of the sweep at cell 10
      @(negedge clk);
      wr_valid = 1'b1; wr_col = 4'd11; wr_row = 2'd2; wr_char = 7'h41; wr_attr = 4'h3;
      clear_req = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0; clear_req = 1'b0;
      check("combo_mem35", dut.u_ram.mem[35], {4'h3, 7'h41});
      check("combo_ready", wr_ready, 0);
      repeat (10) @(negedge clk);
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      count_low(cnt);
      check("restart_len", cnt, CELLS);
      model_clear();
      mem_check("restart_mem");
      scan(60, 100, 78, 78, 1);

      // Reset in the middle of a sweep
      @(negedge clk); clear_req = 1'b1;
      @(negedge clk); clear_req = 1'b0;
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst_ready", wr_ready, 0);
      check("midrst_on", text_on, 0);
      reset_n = 1'b1;
      count_low(cnt);
      check("midrst_clear_len", cnt, CELLS);
      wr(2, 1, 7'h41, 4'b0100, "wr_after_rst");
      scan(96, 112, 128, 132, 2);

      check("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/text_overlay.md
TEXT_OVERLAY -- requirements
Module: text_overlay

Interface
REQ-001 Parameter COLS, default 16, character columns in the text window.
REQ-002 Parameter ROWS, default 4, character rows in the text window.
REQ-003 Parameter SCALE_LOG2, default 1, glyph magnification 2^SCALE_LOG2 (legal 0..3).
REQ-004 Parameter X0, default 64, window left pixel; Y0, default 64, window top pixel.
REQ-005 Parameter BLINK_FRAMES, default 30, frames per blink half-period.
REQ-006 clk  in  1  pixel clock; the single clock of the block.
REQ-007 reset_n  in  1  synchronous active-low reset.
REQ-008 pix_x, pix_y  in  11 each  current pixel coordinate from the VGA sync generator.
REQ-009 frame_tick  in  1  one-cycle pulse at frame start.
REQ-010 wr_valid  in  1; wr_ready  out  1  character-write handshake.
REQ-011 wr_col  in  clog2(COLS); wr_row  in  clog2(ROWS); wr_char  in  7  ASCII code; wr_attr  in  4  (bit3 blink, bits2:0 colour).
REQ-012 clear_req  in  1  pulse requesting a buffer clear.
REQ-013 text_on  out  1  pixel lies on a lit glyph bit; text_rgb  out  3  pixel colour.

Function
REQ-014 Window: COLS*8<<SCALE_LOG2 wide and ROWS*16<<SCALE_LOG2 tall, starting at (X0,Y0); the window position is computed with a subtract followed by a right shift by SCALE_LOG2.
REQ-015 Cell index = row*COLS+col; the cell holds {attr[3:0], char[6:0]}.
REQ-016 Pixel pipeline: stage 1 reads the cell RAM; stage 2 reads the font ROM with {char,row_addr}; stage 3 registers the outputs; the outputs correspond to the pix_x/pix_y sampled 3 cycles earlier.
REQ-017 Row/bit offsets and the in-window flag shall be delayed alongside the pipeline so that all three stay aligned.
REQ-018 font_bit = font_word[~bit_addr], where bit 7 is the leftmost pixel.
REQ-019 text_on=1 only if the pixel is in the window, font_bit=1, and NOT (attr[3]=1 and blink_phase=1).
REQ-020 text_rgb = attr[2:0] when text_on=1, else 3'b000.
REQ-021 FSM states CLEAR and IDLE; CLEAR writes 0x20 with attr 0 to one cell per cycle, from cell 0 to COLS*ROWS-1, then enters IDLE.
REQ-022 wr_ready=1 in IDLE and 0 in CLEAR; a write occurs on the cycle where wr_valid and wr_ready are both 1.
REQ-023 A write with wr_col>=COLS or wr_row>=ROWS is accepted and discarded.
REQ-024 clear_req in IDLE enters CLEAR at the next cycle; clear_req during CLEAR restarts the sweep at cell 0.
REQ-025 clear_req and a handshake in the same IDLE cycle: the write is performed and CLEAR starts on the next cycle.
REQ-026 A read and a write to the same cell in the same cycle return the old data (read-first).
REQ-027 Blink: the frame counter increments on frame_tick; at BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.

Reset
REQ-028 While reset_n=0: text_on=0, text_rgb=0, wr_ready=0, frame counter=0, blink_phase=0, pipeline valid flags=0.
REQ-029 After reset release the FSM is in CLEAR at cell 0; an automatic full clear precedes the first write.
REQ-030 A reset asserted mid-CLEAR aborts the sweep; the sweep restarts from cell 0 after release.

Structure
REQ-031 A shared package holds the cell type {attr,char}, the space code 0x20, and the state encoding.
REQ-032 The existing font_rom shall be instantiated unchanged, with a 1-cycle registered read.
REQ-033 The single new sub-module is text_char_ram: a dual-port, read-first RAM of depth COLS*ROWS and 11-bit width.

Verification
REQ-034 Reset released -> wr_ready=0 for exactly COLS*ROWS cycles, then 1; all cells read 0x20.
REQ-035 Write 'A'(0x41), attr 4'b0010, at (0,0) with SCALE_LOG2=1 -> glyph spans x 64..79 and y 64..95; lit pixels give text_on=1 and rgb=010, 3 cycles after the pixel is presented.
REQ-036 Write with wr_col=COLS -> handshake completes and no cell changes.
REQ-037 Write a cell with attr bit3=1, then apply 2*BLINK_FRAMES frame_ticks -> text_on is suppressed for frames 30..59 and restored at frame 60.
REQ-038 clear_req asserted at sweep cell 10 -> sweep restarts at 0; wr_ready stays 0 for COLS*ROWS further cycles.
